regfile16_wr: RTL
=================

# regfile16_wr

Write side of the 16-entry × 64-bit register file: it accepts write requests through a valid/ready handshake and buffers them in a 2-entry FIFO. Each cycle it decodes the head request's 4-bit address into a one-hot write enable and commits the byte-masked data to the register array. The full array is exported as a packed 16×64 bus that feeds the 16:1 read mux directly. A pending-write mask lets the read side detect read-after-write hazards.

## Interface

Parameters:
- DEPTH, 2, write-buffer entries; legal values 2 only (pointer logic is sized for 2).
- WIDTH, 64, register width in bits; must be a multiple of 8.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- wr_valid  input  1  write request present.
- wr_ready  output  1  buffer can accept; transfer occurs when wr_valid & wr_ready at a rising edge.
- wr_addr  input  4  destination register index.
- wr_data  input  WIDTH  write data.
- wr_be  input  WIDTH/8  byte enables; bit k covers data bits [8k+7:8k].
- wr_hold  input  1  freezes commits; the FIFO still accepts requests while not full.
- q  output  [15:0][WIDTH-1:0]  current register contents, packed; q[n] is register n.
- pend_mask  output  16  bit n set when any buffered entry targets register n.
- pend_cnt  output  2  number of buffered entries (0..2).

## Operation

- Storage: 16 registers, a 2-entry FIFO of {addr, data, be}, a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
- Push occurs when wr_valid & wr_ready. wr_ready = reset_n & (pend_cnt != 2).
- Pop/commit occurs when pend_cnt != 0 & !wr_hold. The head address is decoded to a one-hot 16-bit enable. For every byte k with be[k]=1, reg[addr][8k+7:8k] takes data[8k+7:8k]. Other bytes and other registers hold their values.
- Push and pop in the same cycle: both take effect and the count is unchanged. This cannot occur with count=2, because wr_ready=0 when the buffer is full.
- wr_be = 0: the entry is still pushed and popped, and no register changes.
- Requests with the same address commit in acceptance order, so the last write wins.
- Pointers wrap from 1 to 0.
- pend_mask is the OR of the one-hot decodes of all valid entries. It is combinational from the FIFO state.
- Reset (reset_n=0 at an edge): all registers clear to 0 and the FIFO empties. Any buffered writes are discarded, including writes in flight mid-operation. wr_valid is ignored during reset.

## Timing

- Reset values: q = all 0, pend_mask = 0, pend_cnt = 0. wr_ready = 0 while reset_n = 0, and 1 at the first cycle after the reset edge.
- Latency: a request accepted at edge N (with FIFO empty and wr_hold=0) is committed at edge N+1 and appears on q after edge N+1. pend_mask shows that register during the cycle between N and N+1.
- With the FIFO empty and no hold, sustained throughput is 1 write/cycle and pend_cnt stays at 1.
- wr_hold=1 for H cycles lets at most 2 requests buffer. wr_ready drops the cycle after the second accept. Commits resume at the first edge with wr_hold=0, at one per cycle.
- q changes only at rising edges. There is no combinational path from wr_data to q.

## Configuration

- REGFILE_ZERO_REG_EN defined: register 15 is hardwired to zero. q[15] always reads 0. Commits to address 15 are popped normally but update nothing. Requests to address 15 still set pend_mask[15] while buffered.
- REGFILE_ZERO_REG_EN undefined: register 15 is an ordinary register, identical to registers 0..14.

## Test plan

- Reset: drive reset_n=0 for 2 edges with wr_valid=1 → q all 0, pend_cnt=0, wr_ready=0. After release, wr_ready=1.
- Single write: addr=3, data=64'd12328, be=8'hFF, accepted at edge N → pend_mask=16'h0008 before edge N+1. q[3]=12328 after edge N+1, and all other registers remain 0.
- Byte mask: q[5]=64'h0, then write 64'h1122334455667788 with be=8'h0F → q[5]=64'h0000000055667788.
- Hold/full: wr_hold=1, push addr 1 then addr 2 → pend_cnt=2, wr_ready=0, pend_mask=16'h0006. Release hold → q[1] updates at the first edge and q[2] at the next, then pend_cnt=0.
- Ordering: back-to-back writes to addr 7 of 64'd157 then 64'd2803 → q[7] ends at 2803.
- Zero register: write 64'd538129 to addr 15 → q[15]=0 with REGFILE_ZERO_REG_EN defined, and 538129 without it. Assert reset_n=0 while an entry is buffered → that entry is discarded.

Source files
------------

// File: rtl/regfile16_wr.sv
// Write side of a 16 x WIDTH register file: 2-entry request buffer, byte-masked commit, pending-write mask.
// Optional: REGFILE_ZERO_REG_EN hardwires register 15 to zero.
module regfile16_wr #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [3:0]                 wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [WIDTH/8-1:0]         wr_be,
    input  logic                       wr_hold,
    output logic [15:0][WIDTH-1:0]     q,
    output logic [15:0]                pend_mask,
    output logic [1:0]                 pend_cnt
);

    localparam int unsigned NREG  = 16;
    localparam int unsigned NBYTE = WIDTH / 8;

    typedef struct packed {
        logic [3:0]       addr;
        logic [WIDTH-1:0] data;
        logic [NBYTE-1:0] be;
    } wr_req_t;

    logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
    wr_req_t                    fifo_q [DEPTH];
    wr_req_t                    fifo_d [DEPTH];
    logic                       rd_ptr_q, rd_ptr_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic [1:0]                 cnt_q, cnt_d;

    logic                       push_c;
    logic                       pop_c;
    wr_req_t                    head_c;
    logic [NREG-1:0]            wen_c;

    assign wr_ready  = reset_n & (cnt_q != 2'd2);
    assign push_c    = wr_valid & wr_ready;
    assign pop_c     = (cnt_q != 2'd0) & ~wr_hold;
    assign head_c    = fifo_q[rd_ptr_q];
    assign wen_c     = pop_c ? (NREG'(1) << head_c.addr) : '0;
    assign q         = regs_q;
    assign pend_cnt  = cnt_q;

    // Next-state: buffer push/pop bookkeeping and byte-masked commit of the head entry
    always_comb begin
        regs_d   = regs_q;
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        if (push_c) begin
            fifo_d[wr_ptr_q] = '{addr: wr_addr, data: wr_data, be: wr_be};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push_c, pop_c})
            2'b10:   cnt_d = 2'(cnt_q + 2'd1);
            2'b01:   cnt_d = 2'(cnt_q - 2'd1);
            default: cnt_d = cnt_q;
        endcase

        for (int r = 0; r < NREG; r++) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (wen_c[r] && head_c.be[k]) begin
                    regs_d[r][8*k +: 8] = head_c.data[8*k +: 8];
                end
            end
        end

`ifdef REGFILE_ZERO_REG_EN
        regs_d[NREG-1] = '0;
`else
`endif
    end

    // Synchronous reset clears the array and drops any buffered writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            regs_q   <= regs_d;
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pending mask covers only occupied slots: head when count>=1, the other slot when full
    always_comb begin
        pend_mask = '0;
        if (cnt_q != 2'd0) begin
            pend_mask = pend_mask | (NREG'(1) << fifo_q[rd_ptr_q].addr);
        end
        if (cnt_q == 2'd2) begin
            pend_mask = pend_mask | (NREG'(1) << fifo_q[~rd_ptr_q].addr);
        end
    end

endmodule
